// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states, CSR addresses, causes, opcodes.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package trap_ctrl_pkg;

    // Trap sequencer states. The encoding is fixed so waveforms stay readable across builds.
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_MEPC         = 3'd1,
        ST_MCAUSE       = 3'd2,
        ST_MSTATUS      = 3'd3,
        ST_ASSERT       = 3'd4,
        ST_MRET_MSTATUS = 3'd5,
        ST_MRET_ASSERT  = 3'd6
    } trap_state_t;

    // Machine-mode CSR addresses touched by the trap path.
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Synchronous exception cause codes (mcause bit 31 clear).
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    // Full 32-bit encodings of the system instructions that enter or leave a trap.
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // mstatus bit positions.
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // mstatus on trap entry: stash MIE into MPIE, then disable interrupts.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] old);
        logic [31:0] nxt;
        nxt               = old;
        nxt[MSTATUS_MPIE] = old[MSTATUS_MIE];
        nxt[MSTATUS_MIE]  = 1'b0;
        return nxt;
    endfunction

    // mstatus on MRET: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] old);
        logic [31:0] nxt;
        nxt               = old;
        nxt[MSTATUS_MIE]  = old[MSTATUS_MPIE];
        nxt[MSTATUS_MPIE] = 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending interrupt lines.
// Latency: purely combinational.
// Backpressure: none; the consumer samples grant/idx whenever vld is high.
module irq_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the last hit, the lowest index, is what remains.
    always_comb begin
        grant = '0;
        idx   = '0;
        vld   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: ECALL/EBREAK, external interrupts and MRET via mepc/mcause/mstatus writes.
// Latency: accept in IDLE at cycle 0 -> trap redirect at cycle 4, MRET redirect at cycle 2.
// Backpressure: hold_o stalls the pipeline for the whole sequence; nothing new is accepted until IDLE.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int NUM_IRQ        = 8,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter int VECTORED_EN    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               div_started_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    output logic               hold_o,
    output logic               csr_we_o,
    output logic [11:0]        csr_waddr_o,
    output logic [31:0]        csr_wdata_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [NUM_IRQ-1:0] irq_claim_o
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    trap_state_t        state;

    // Context captured when a trap is accepted, so later input changes cannot disturb the sequence.
    logic [31:0]        cause_q;
    logic               is_irq_q;
    logic [NUM_IRQ-1:0] claim_q;

    logic [NUM_IRQ-1:0] irq_pend;
    logic [NUM_IRQ-1:0] irq_grant;
    logic [IDX_W-1:0]   irq_idx;
    logic               irq_vld;

    logic               is_sync;
    logic               sync_take;
    logic               irq_take;
    logic               mret_take;
    logic               accept;

    logic [31:0]        sync_cause;
    logic [31:0]        irq_cause;
    logic [31:0]        irq_ret;
    logic [31:0]        trap_base;
    logic [31:0]        trap_tgt;

    assign irq_pend = irq_i & irq_en_i;

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_irq_prio_enc (
        .req   (irq_pend),
        .grant (irq_grant),
        .idx   (irq_idx),
        .vld   (irq_vld)
    );

    // Event arbitration: a sync exception waits out a running divide; interrupts may still win meanwhile.
    always_comb begin
        is_sync   = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
        sync_take = is_sync && !div_started_i;
        irq_take  = !sync_take && irq_vld && csr_mstatus_i[MSTATUS_MIE];
        mret_take = !sync_take && !irq_take && (inst_i == INST_MRET);
        accept    = (state == ST_IDLE) && (sync_take || irq_take || mret_take);
    end

    // Stall the pipeline from the accepting cycle until the sequencer is idle again.
    assign hold_o = !rst && ((state != ST_IDLE) || accept);

    // Cause and return address for the event being accepted this cycle.
    always_comb begin
        sync_cause = (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL_M;
        irq_cause  = {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(irq_idx)};
        // A taken branch means the next instruction is the jump target; a divide in
        // flight means the instruction ahead of decode has not retired yet.
        irq_ret    = inst_addr_i;
        if (jump_flag_i) begin
            irq_ret = jump_addr_i;
        end else if (div_started_i) begin
            irq_ret = inst_addr_i - 32'd4;
        end
    end

    // Trap entry point: vectored interrupts land at base + 4*cause code, everything else at base.
    always_comb begin
        trap_base = {csr_mtvec_i[31:2], 2'b00};
        trap_tgt  = trap_base;
        if ((VECTORED_EN != 0) && is_irq_q && (csr_mtvec_i[1:0] == 2'b01)) begin
            trap_tgt = trap_base + {cause_q[29:0], 2'b00};
        end
    end

    // Trap/MRET sequencer with registered CSR-write and redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cause_q      <= '0;
            is_irq_q     <= 1'b0;
            claim_q      <= '0;
            csr_we_o     <= 1'b0;
            csr_waddr_o  <= '0;
            csr_wdata_o  <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
            irq_claim_o  <= '0;
        end else begin
            // Outputs are single-cycle pulses; each state below re-asserts what it needs.
            csr_we_o     <= 1'b0;
            csr_waddr_o  <= '0;
            csr_wdata_o  <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
            irq_claim_o  <= '0;

            case (state)
                ST_IDLE: begin
                    if (sync_take || irq_take) begin
                        state       <= ST_MEPC;
                        cause_q     <= sync_take ? sync_cause : irq_cause;
                        is_irq_q    <= irq_take;
                        claim_q     <= sync_take ? '0 : irq_grant;
                        csr_we_o    <= 1'b1;
                        csr_waddr_o <= CSR_MEPC;
                        csr_wdata_o <= sync_take ? inst_addr_i : irq_ret;
                    end else if (mret_take) begin
                        state       <= ST_MRET_MSTATUS;
                        csr_we_o    <= 1'b1;
                        csr_waddr_o <= CSR_MSTATUS;
                        csr_wdata_o <= mstatus_on_mret(csr_mstatus_i);
                    end
                end

                ST_MEPC: begin
                    state       <= ST_MCAUSE;
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= CSR_MCAUSE;
                    csr_wdata_o <= cause_q;
                end

                ST_MCAUSE: begin
                    state       <= ST_MSTATUS;
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= CSR_MSTATUS;
                    csr_wdata_o <= mstatus_on_trap(csr_mstatus_i);
                end

                ST_MSTATUS: begin
                    state        <= ST_ASSERT;
                    int_assert_o <= 1'b1;
                    int_addr_o   <= trap_tgt;
                    irq_claim_o  <= claim_q;
                end

                ST_ASSERT: begin
                    state    <= ST_IDLE;
                    cause_q  <= '0;
                    is_irq_q <= 1'b0;
                    claim_q  <= '0;
                end

                ST_MRET_MSTATUS: begin
                    state        <= ST_MRET_ASSERT;
                    int_assert_o <= 1'b1;
                    int_addr_o   <= csr_mepc_i;
                end

                ST_MRET_ASSERT: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected CSR writes/redirects queued at stimulus, popped by a monitor.
// Latency: checks exact cycle of every write/redirect relative to the accepting cycle.
// Backpressure: checks hold_o inline in each scenario.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int NUM_IRQ = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        inst_i, inst_addr_i, jump_addr_i;
    logic               jump_flag_i, div_started_i;
    logic [NUM_IRQ-1:0] irq_i, irq_en_i;
    logic [31:0]        csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic               hold_o, csr_we_o, int_assert_o;
    logic [11:0]        csr_waddr_o;
    logic [31:0]        csr_wdata_o, int_addr_o;
    logic [NUM_IRQ-1:0] irq_claim_o;

    typedef struct {
        logic               is_int;
        logic [11:0]        addr;
        logic [31:0]        data;
        logic [NUM_IRQ-1:0] claim;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    trap_ctrl #(
        .NUM_IRQ        (NUM_IRQ),
        .IRQ_CAUSE_BASE (16),
        .VECTORED_EN    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_i        (inst_i),
        .inst_addr_i   (inst_addr_i),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .div_started_i (div_started_i),
        .irq_i         (irq_i),
        .irq_en_i      (irq_en_i),
        .csr_mtvec_i   (csr_mtvec_i),
        .csr_mepc_i    (csr_mepc_i),
        .csr_mstatus_i (csr_mstatus_i),
        .hold_o        (hold_o),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .int_assert_o  (int_assert_o),
        .int_addr_o    (int_addr_o),
        .irq_claim_o   (irq_claim_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_i        = NOP;
        irq_i         = '0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = '0;
        div_started_i = 1'b0;
    endtask

    task automatic push_csr(input logic [11:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.is_int = 1'b0; e.addr = a; e.data = d; e.claim = '0; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_int(input logic [31:0] t, input logic [NUM_IRQ-1:0] cl, input int c);
        exp_t e;
        e.is_int = 1'b1; e.addr = '0; e.data = t; e.claim = cl; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] mst,
                             input logic [31:0] tgt, input logic [NUM_IRQ-1:0] cl, input int c0);
        push_csr(12'h341, epc, c0 + 1);
        push_csr(12'h342, cause, c0 + 2);
        push_csr(12'h300, mst, c0 + 3);
        push_int(tgt, cl, c0 + 4);
    endtask

    // Pops the scoreboard on every write/redirect pulse; otherwise checks the quiet outputs are zero.
    task automatic monitor();
        exp_t        e;
        logic [31:0] got_d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (csr_we_o || int_assert_o) begin
                    got_d = int_assert_o ? int_addr_o : csr_wdata_o;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output cyc=%0d we=%b waddr=%h wdata=%h int=%b iaddr=%h, required no output",
                                 cyc, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
                    end else begin
                        e = sb.pop_front();
                        if ({int_assert_o, csr_we_o, csr_waddr_o, got_d, irq_claim_o} !==
                                {e.is_int, !e.is_int, e.addr, e.data, e.claim} || cyc != e.cyc) begin
                            failures++;
                            $display("FAIL sb_entry got int=%b we=%b addr=%h data=%h claim=%h cyc=%0d, required int=%b addr=%h data=%h claim=%h cyc=%0d",
                                     int_assert_o, csr_we_o, csr_waddr_o, got_d, irq_claim_o, cyc,
                                     e.is_int, e.addr, e.data, e.claim, e.cyc);
                        end
                    end
                end else if ({csr_waddr_o, csr_wdata_o, int_addr_o, irq_claim_o} !== '0) begin
                    failures++;
                    $display("FAIL quiet_zero cyc=%0d waddr=%h wdata=%h iaddr=%h claim=%h, required all 0",
                             cyc, csr_waddr_o, csr_wdata_o, int_addr_o, irq_claim_o);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        inst_i        = INST_ECALL;
        irq_i         = 8'hFF;
        irq_en_i      = 8'hFF;
        csr_mstatus_i = 32'h8;
        csr_mtvec_i   = 32'h1000;
        csr_mepc_i    = 32'h0;
        inst_addr_i   = 32'h0;
        #12;
        checks++;
        if ({hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, irq_claim_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs hold=%b we=%b waddr=%h wdata=%h int=%b iaddr=%h claim=%h, required all 0",
                     hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, irq_claim_o);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (hold_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_hold got %b, required 0", hold_o);
        end
    endtask

    task automatic test_ecall();
        int c0;
        csr_mtvec_i = 32'h1000; csr_mstatus_i = 32'h8;
        tick();
        inst_i = INST_ECALL; inst_addr_i = 32'h100; c0 = cyc;
        push_trap(32'h100, 32'd11, 32'h80, 32'h1000, '0, c0);
        #1;
        checks++;
        if (hold_o !== 1'b1) begin failures++; $display("FAIL ecall_hold_accept got %b, required 1", hold_o); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hold_o !== 1'b1) begin failures++; $display("FAIL ecall_hold_busy got %b, required 1", hold_o); end
        repeat (6) tick();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL ecall_drain left %0d, required 0", sb.size()); end
    endtask

    task automatic test_irq_vectored();
        int c0;
        csr_mtvec_i = 32'h8001; csr_mstatus_i = 32'h8; irq_en_i = 8'hFF;
        tick();
        irq_i = 8'h28; inst_addr_i = 32'h300; c0 = cyc;
        push_trap(32'h300, 32'h8000_0013, 32'h80, 32'h804C, 8'h08, c0);
        tick();
        irq_i = 8'h01;          // a different line mid-sequence must not change the claim
        tick();
        idle_inputs();
        repeat (6) tick();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL irq_vec_drain left %0d, required 0", sb.size()); end
    endtask

    task automatic test_irq_retaddr();
        int c0;
        csr_mtvec_i = 32'h8001; csr_mstatus_i = 32'h8; irq_en_i = 8'hFF;
        tick();
        irq_i = 8'h01; jump_flag_i = 1'b1; jump_addr_i = 32'h200; inst_addr_i = 32'h500; c0 = cyc;
        push_trap(32'h200, 32'h8000_0010, 32'h80, 32'h8040, 8'h01, c0);
        tick();
        idle_inputs();
        repeat (6) tick();
        csr_mtvec_i = 32'h2000;
        irq_i = 8'h80; div_started_i = 1'b1; inst_addr_i = 32'h400; c0 = cyc;
        push_trap(32'h3FC, 32'h8000_0017, 32'h80, 32'h2000, 8'h80, c0);
        tick();
        idle_inputs();
        repeat (6) tick();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL irq_ret_drain left %0d, required 0", sb.size()); end
    endtask

    task automatic test_mie_off();
        csr_mstatus_i = 32'h0; irq_en_i = 8'hFF;
        tick();
        irq_i = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (hold_o !== 1'b0) begin failures++; $display("FAIL mie_off_hold got %b, required 0", hold_o); end
            tick();
        end
        csr_mstatus_i = 32'h8; irq_en_i = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (hold_o !== 1'b0) begin failures++; $display("FAIL irq_en_off_hold got %b, required 0", hold_o); end
            tick();
        end
        idle_inputs();
        irq_en_i = 8'hFF;
        tick();
    endtask

    task automatic test_ecall_div();
        int c0;
        csr_mtvec_i = 32'h1000; csr_mstatus_i = 32'h8;
        tick();
        inst_i = INST_ECALL; inst_addr_i = 32'h140; div_started_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (hold_o !== 1'b0) begin failures++; $display("FAIL div_defer_hold got %b, required 0", hold_o); end
            tick();
        end
        div_started_i = 1'b0; c0 = cyc;
        push_trap(32'h140, 32'd11, 32'h80, 32'h1000, '0, c0);
        #1;
        checks++;
        if (hold_o !== 1'b1) begin failures++; $display("FAIL div_release_hold got %b, required 1", hold_o); end
        tick();
        idle_inputs();
        repeat (6) tick();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL ecall_div_drain left %0d, required 0", sb.size()); end
    endtask

    task automatic test_mret();
        int c0;
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
        tick();
        inst_i = INST_MRET; c0 = cyc;
        push_csr(12'h300, 32'h88, c0 + 1);
        push_int(32'h104, '0, c0 + 2);
        #1;
        checks++;
        if (hold_o !== 1'b1) begin failures++; $display("FAIL mret_hold got %b, required 1", hold_o); end
        tick();
        idle_inputs();
        repeat (5) tick();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL mret_drain left %0d, required 0", sb.size()); end
    endtask

    task automatic test_priority();
        int c0;
        csr_mtvec_i = 32'h1000; csr_mstatus_i = 32'h8; irq_en_i = 8'hFF;
        tick();
        inst_i = INST_ECALL; irq_i = 8'h04; inst_addr_i = 32'h180; c0 = cyc;
        push_trap(32'h180, 32'd11, 32'h80, 32'h1000, '0, c0);
        tick();
        idle_inputs();
        repeat (6) tick();
        csr_mstatus_i = 32'h88;
        inst_i = INST_MRET; irq_i = 8'h02; inst_addr_i = 32'h1A0; c0 = cyc;
        push_trap(32'h1A0, 32'h8000_0011, 32'h80, 32'h1000, 8'h02, c0);
        tick();
        idle_inputs();
        repeat (6) tick();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL priority_drain left %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int c0;
        csr_mtvec_i = 32'h1000; csr_mstatus_i = 32'h8;
        tick();
        inst_i = INST_ECALL; inst_addr_i = 32'h1C0; c0 = cyc;
        push_csr(12'h341, 32'h1C0, c0 + 1);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h342) begin
            failures++;
            $display("FAIL mid_mcause got we=%b waddr=%h, required we=1 waddr=342", csr_we_o, csr_waddr_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, irq_claim_o} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs hold=%b we=%b waddr=%h wdata=%h int=%b iaddr=%h, required all 0",
                     hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (6) begin
            tick();
            checks++;
            if (hold_o !== 1'b0) begin failures++; $display("FAIL post_reset_hold got %b, required 0", hold_o); end
        end
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL reset_mid_drain left %0d, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int c0;
        csr_mtvec_i = 32'h1000; csr_mstatus_i = 32'h8;
        tick();
        inst_i = INST_EBREAK; inst_addr_i = 32'h1E0; c0 = cyc;
        push_trap(32'h1E0, 32'd3, 32'h80, 32'h1000, '0, c0);
        push_trap(32'h1E0, 32'd3, 32'h80, 32'h1000, '0, c0 + 5);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (hold_o !== 1'b1) begin failures++; $display("FAIL b2b_hold cycle %0d got %b, required 1", i, hold_o); end
            tick();
        end
        idle_inputs();
        repeat (5) tick();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL b2b_drain left %0d, required 0", sb.size()); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_ecall();
        test_irq_vectored();
        test_irq_retaddr();
        test_mie_off();
        test_ecall_div();
        test_mret();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
